// File: rtl/cdc_hs_pkg.sv
// Shared types and defaults for the 4-phase req/ack CDC handshake blocks.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } hs_tx_state_t;

  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1023;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit N-flop synchronizer; used for ack on the transmit side and req on the receive side.
module cdc_sync_bit
  import cdc_hs_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d = {sync_q[STAGES-2:0], i_d};
  assign o_q    = sync_q[STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

endmodule

// File: rtl/cdc_hs_tx.sv
// Transmit end of a 4-phase req/ack CDC handshake carrying one DATA_W word per transfer.
// Define CDC_HS_TX_TIMEOUT_EN to build the per-phase watchdog that drives o_timeout.
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_req,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout
);

  hs_tx_state_t      state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              ack_s;
  logic              accept;
  logic              expire;
  logic              aborted;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_ack),
    .o_q     (ack_s)
  );

  assign o_ready = (state_q == IDLE) && !ack_s;
  assign accept  = o_ready && i_valid;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = i_data;
          req_d   = 1'b1;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_s || expire) begin
          req_d   = 1'b0;
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        // A transfer aborted in REQ_HI still returns through REQ_LO but reports no completion.
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = !aborted;
        end else if (expire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aborted_q, aborted_d;
  logic             timeout_q, timeout_d;

  assign expire  = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign aborted = aborted_q;

  always_comb begin
    cnt_d = '0;
    if ((state_q != IDLE) && (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
    aborted_d = aborted_q;
    if (accept) begin
      aborted_d = 1'b0;
    end else if ((state_q == REQ_HI) && !ack_s && expire) begin
      aborted_d = 1'b1;
    end
    timeout_d = expire && (((state_q == REQ_HI) && !ack_s) ||
                           ((state_q == REQ_LO) && ack_s));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      aborted_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign expire             = 1'b0;
  assign aborted            = 1'b0;
  assign o_timeout          = 1'b0;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  assign o_req  = req_q;
  assign o_data = data_q;
  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed self-checking bench for cdc_hs_tx with a small destination-side ack model.
module tb_cdc_hs_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = '0;
  logic       ready, req, busy, done, tmo;
  logic [7:0] odata;
  logic       ack_w;
  logic       ack_model;
  logic       ack_force = 1'b0;
  logic       dst_en = 1'b0;
  logic [1:0] dly;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_rise = 0;
  int n_tmo  = 0;
  int n_chg  = 0;
  logic       last_req  = 1'b0;
  logic       last_busy = 1'b0;
  logic [7:0] last_data = '0;

  always #5 clk = ~clk;

  assign ack_w = dst_en ? ack_model : ack_force;

  cdc_hs_tx #(
    .DATA_W         (8),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .o_ready   (ready),
    .i_data    (data),
    .o_req     (req),
    .o_data    (odata),
    .i_ack     (ack_w),
    .o_busy    (busy),
    .o_done    (done),
    .o_timeout (tmo)
  );

  // Destination: raises ack on the 3rd edge after seeing req, drops it 3 edges after req falls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_model <= 1'b0;
      dly       <= '0;
    end else if (!dst_en) begin
      ack_model <= 1'b0;
      dly       <= '0;
    end else if (req != ack_model) begin
      if (dly == 2'd2) begin
        ack_model <= req;
        dly       <= '0;
      end else begin
        dly <= dly + 2'd1;
      end
    end else begin
      dly <= '0;
    end
  end

  always @(negedge clk) begin
    if (done) n_done <= n_done + 1;
    if (tmo) n_tmo <= n_tmo + 1;
    if (req && !last_req) n_rise <= n_rise + 1;
    if (busy && last_busy && (odata != last_data)) n_chg <= n_chg + 1;
    last_req  <= req;
    last_busy <= busy;
    last_data <= odata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 50) begin
      tick();
      n++;
    end
    check(tag, ready, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (n_done < target && n < 100) begin
      tick();
      n++;
    end
    tick();
    check(tag, n_done, target);
  endtask

  task automatic send(input string tag, input logic [7:0] w);
    wait_ready({tag, "_rdy"});
    data  = w;
    valid = 1'b1;
    check({tag, "_req_pre"}, req, 1'b0);
    tick();
    valid = 1'b0;
    check({tag, "_req_rise"}, req, 1'b1);
    check({tag, "_data"}, odata, w);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int d0, r0, t0, nhi;
    logic [7:0] words [3];
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_ready", ready, 1'b1);
    check("rst_req", req, 1'b0);
    check("rst_data", odata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tmo", tmo, 1'b0);

    // Single transfer 0xA5
    dst_en = 1'b1;
    d0 = n_done;
    r0 = n_rise;
    send("a5", 8'hA5);
    check("a5_busy", busy, 1'b1);
    wait_done("a5_done", d0 + 1);
    check("a5_rises", n_rise - r0, 1);
    check("a5_hold", odata, 8'hA5);
    check("a5_ready_back", ready, 1'b1);

    // Back-to-back with valid held high
    d0 = n_done;
    r0 = n_rise;
    valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data = words[k];
      wait_ready("b2b_rdy");
      tick();
      check("b2b_req", req, 1'b1);
      check("b2b_data", odata, words[k]);
    end
    valid = 1'b0;
    wait_done("b2b_done", d0 + 3);
    check("b2b_rises", n_rise - r0, 3);
    check("b2b_last", odata, 8'h03);

    // Valid while in REQ_HI is ignored
    d0 = n_done;
    r0 = n_rise;
    send("hi", 8'h5A);
    tick();
    data  = 8'hFF;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("hi_ignore_data", odata, 8'h5A);
    check("hi_busy", busy, 1'b1);
    wait_done("hi_done", d0 + 1);
    check("hi_rises", n_rise - r0, 1);
    check("hi_final_data", odata, 8'h5A);

    // Stale ack held across reset release
    dst_en    = 1'b0;
    ack_force = 1'b1;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    data  = 8'h3C;
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stale_ready", ready, 1'b0);
      check("stale_busy", busy, 1'b0);
    end
    ack_force = 1'b0;
    tick();
    check("stale_sync1_ready", ready, 1'b0);
    check("stale_sync1_busy", busy, 1'b0);
    tick();
    check("stale_sync2_ready", ready, 1'b1);
    check("stale_sync2_busy", busy, 1'b0);
    d0 = n_done;
    dst_en = 1'b1;
    tick();
    valid = 1'b0;
    check("stale_accept_busy", busy, 1'b1);
    check("stale_accept_data", odata, 8'h3C);
    wait_done("stale_done", d0 + 1);

`ifdef CDC_HS_TX_TIMEOUT_EN
    // Watchdog expiry in REQ_HI with ack never arriving
    dst_en = 1'b0;
    d0 = n_done;
    t0 = n_tmo;
    send("tmo", 8'h77);
    nhi = 0;
    while (req && nhi < 100) begin
      nhi++;
      tick();
    end
    check("tmo_req_cycles_ok", (nhi >= 15 && nhi <= 16), 1'b1);
    check("tmo_req_low", req, 1'b0);
    check("tmo_pulse", tmo, 1'b1);
    tick();
    check("tmo_pulse_end", tmo, 1'b0);
    tick();
    check("tmo_idle", busy, 1'b0);
    check("tmo_ready", ready, 1'b1);
    check("tmo_count", n_tmo - t0, 1);
    check("tmo_no_done", n_done - d0, 0);
    dst_en = 1'b1;
`else
    t0  = 0;
    nhi = 0;
`endif

    // Reset during REQ_HI
    dst_en = 1'b0;
    send("rmid", 8'h11);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rmid_req", req, 1'b0);
    check("rmid_busy", busy, 1'b0);
    check("rmid_data", odata, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    dst_en = 1'b1;
    d0 = n_done;
    send("rnext", 8'h22);
    wait_done("rnext_done", d0 + 1);
    check("rnext_data", odata, 8'h22);

    check("data_stable_while_busy", n_chg, 0);
`ifndef CDC_HS_TX_TIMEOUT_EN
    check("no_timeout_pulses", n_tmo, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx.md
Name: cdc_hs_tx

Overview:
- Source-domain (transmit) end of a 4-phase req/ack CDC handshake for a multi-bit word.
- Accepts a word via valid/ready on i_clk, holds it stable on o_data, and raises o_req toward the destination domain.
- Brings the destination's asynchronous i_ack back through an internal multi-flop synchronizer, then completes the return-to-zero phase.
- Pairs with the destination-side req synchronizer and capture logic.

Parameters:
- DATA_W, 8, width of transferred word.
- SYNC_STAGES, 2, flops in the i_ack synchronizer chain; legal values are 2 or more.
- TIMEOUT_CYCLES, 1023, handshake-phase watchdog limit. Used only with the optional feature.

Ports:
- i_clk  in  1  source-domain clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  block can accept a word this cycle.
- i_data  in  DATA_W  upstream word.
- o_req  out  1  handshake request to destination; driven directly from a flop.
- o_data  out  DATA_W  held word to destination; driven directly from a register.
- i_ack  in  1  destination acknowledge, asynchronous to i_clk.
- o_busy  out  1  handshake in progress (state != IDLE).
- o_done  out  1  one-cycle pulse when a transfer completes normally.
- o_timeout  out  1  one-cycle pulse on watchdog expiry; tied 0 when the feature is compiled out.

Behaviour:
- Reset values: o_req=0, o_data=0, o_done=0, o_timeout=0, state=IDLE, all sync flops=0, so o_ready=1 after reset.
- ack_s is the output of the SYNC_STAGES-deep chain on i_ack. All FSM decisions use ack_s only; raw i_ack never reaches logic.
- o_ready = (state==IDLE) && !ack_s. This is combinational from registered values.
- Acceptance happens in the cycle where i_valid && o_ready:
  - o_data <= i_data and o_req <= 1 at the next edge.
  - State becomes REQ_HI.
  - o_req rises the cycle after acceptance.
- REQ_HI: o_req held 1. On ack_s==1: o_req <= 0, state goes to REQ_LO.
- REQ_LO: o_req held 0. On ack_s==0: state goes to IDLE and o_done pulses for 1 cycle (registered, same edge as the state change).
- o_data is held unchanged from acceptance until the next acceptance. It is never modified while busy.
- Round-trip latency from acceptance to o_done is at least 2*SYNC_STAGES + 2 cycles, plus destination-side delays.
- Back-to-back transfers: the next word can be accepted in the cycle IDLE is re-entered, provided ack_s==0.
- Stale ack: if ack_s==1 while in IDLE (e.g. the destination left reset later), o_ready stays 0 until ack_s drops.
- i_valid while busy is ignored; no data is captured.
- i_data changes without acceptance have no effect.
- Reset asserted mid-handshake: immediate return to reset values. The destination must be reset concurrently; otherwise the stale-ack rule handles recovery.

Optional Feature:
- Macro: CDC_HS_TX_TIMEOUT_EN.
- With the macro defined:
  - A phase counter clears on entry to REQ_HI and REQ_LO and increments each cycle in those states.
  - Expiry in REQ_HI (count==TIMEOUT_CYCLES, ack_s still 0): o_req <= 0, o_timeout pulses 1 cycle, state goes to REQ_LO. No o_done for that transfer.
  - Expiry in REQ_LO (ack_s still 1): o_timeout pulses, state goes to IDLE. The stale-ack rule keeps o_ready low until ack_s==0.
- Without the macro: no counter is built, o_timeout is constant 0, and the block waits indefinitely in each phase.

Decomposition:
- Package cdc_hs_pkg holds:
  - enum typedef hs_tx_state_t {IDLE, REQ_HI, REQ_LO}, 2 bits;
  - localparam default SYNC_STAGES=2;
  - default TIMEOUT_CYCLES=1023.
- Sub-module cdc_sync_bit: a parameterized single-bit N-flop synchronizer, instantiated once for i_ack. It also serves as the request synchronizer on the receive side.

Test Plan:
- Reset release with i_ack=0 -> o_ready=1, o_req=0, o_data=0x00 on the first cycle after reset.
- Accept i_data=0xA5 with a destination model acking 3 cycles after seeing req and de-asserting ack 3 cycles after req falls, SYNC_STAGES=2:
  - o_req rises 1 cycle after acceptance;
  - o_data=0xA5 stable throughout;
  - one o_done pulse;
  - o_ready returns.
- Back-to-back words 0x01, 0x02, 0x03 with i_valid held high -> exactly three handshakes, o_data sequence 0x01/0x02/0x03, three o_done pulses, no word skipped or duplicated.
- Hold i_ack=1 at reset release -> o_ready=0 for SYNC_STAGES cycles after i_ack falls; i_valid=1 meanwhile is not accepted.
- i_valid pulses with 0xFF while in REQ_HI -> ignored; o_data keeps the previous word; no extra handshake.
- Timeout, macro defined, TIMEOUT_CYCLES=15, i_ack held 0 -> o_req drops after 15 cycles in REQ_HI, o_timeout pulses once, no o_done, FSM returns to IDLE.
- Reset asserted during REQ_HI -> o_req=0 and o_busy=0 immediately; the next transfer completes normally.
